// File: rtl/mem_copy_engine.sv
// Byte-serial, overlap-safe copy engine driving a single-port 64-byte memory.
// Requests are validated on START; each byte takes READ, WAIT and WRITE cycles.
module mem_copy_engine #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [5:0]        SRC,
  input  logic [5:0]        DST,
  input  logic [6:0]        LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_D_IN,
  output logic              MEM_R_ENABLE,
  output logic              MEM_W_ENABLE,
  input  logic [DATA_W-1:0] MEM_D_OUT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4,
    S_REJECT = 3'd5
  } state_e;

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  state_e              state_q, state_d;
  logic [5:0]          src_q, src_d, dst_q, dst_d, idx_q, idx_d;
  logic [6:0]          rem_q, rem_d;
  logic                desc_q, desc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]          src_end_s, dst_end_s;
  logic [6:0]          last_idx_s;
  logic [5:0]          byte_addr_s;
  logic                valid_s;

  // Request validation; 8-bit sums so an oversize LEN can never wrap into range.
  always_comb begin
    src_end_s  = {2'b00, SRC} + {1'b0, LEN};
    dst_end_s  = {2'b00, DST} + {1'b0, LEN};
    last_idx_s = LEN - 7'd1;
    valid_s    = (LEN != 7'd0) && (src_end_s <= DEPTH_L) && (dst_end_s <= DEPTH_L);
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    desc_d      = desc_q;
    data_d      = data_q;
    byte_addr_s = 6'd0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          src_d   = SRC;
          dst_d   = DST;
          rem_d   = LEN;
          desc_d  = (DST > SRC) && ({2'b00, DST} < src_end_s);
          idx_d   = desc_d ? last_idx_s[5:0] : 6'd0;
          state_d = valid_s ? S_READ : S_REJECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        data_d  = MEM_D_OUT;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rem_d   = rem_q - 7'd1;
        idx_d   = desc_q ? (idx_q - 6'd1) : (idx_q + 6'd1);
        state_d = (rem_q == 7'd1) ? S_FINISH : S_READ;
      end
      S_FINISH: state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_READ);
    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH) || (state_d == S_REJECT);
    err_d   = (state_d == S_REJECT);
    if (state_d == S_READ) begin
      byte_addr_s = src_d + idx_d;
      addr_d      = {{(ADDR_W-6){1'b0}}, byte_addr_s};
    end else if (state_d == S_WRITE) begin
      byte_addr_s = dst_d + idx_d;
      addr_d      = {{(ADDR_W-6){1'b0}}, byte_addr_s};
    end else begin
      addr_d = addr_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      src_q   <= 6'd0;
      dst_q   <= 6'd0;
      idx_q   <= 6'd0;
      rem_q   <= 7'd0;
      desc_q  <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      desc_q  <= desc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign MEM_ADDR     = addr_q;
  assign MEM_D_IN     = data_q;
  assign MEM_R_ENABLE = rd_en_q;
  assign MEM_W_ENABLE = wr_en_q;

endmodule
